serial_magnitude_comparator: RTL and testbench

//   Sequential, bit-serial counterpart of the 8-bit ripple magnitude comparator: same
//   l/e/g result, but scanned LSB-first, one bit per clock, by a single shared 1-bit stage.

---
 rtl/serial_magnitude_comparator.sv | 158 +++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Bit-serial magnitude comparator. Operands are latched on an accepted start and
//   then scanned LSB-first, one bit per clock, through a single 1-bit compare stage.
//   A difference at a higher bit overrides whatever the lower bits decided.
//   The registered l/e/g result changes only when a scan completes.
//
//   Optional build macro: SERIAL_CMP_SIGNED_EN
//     defined   - operands are two's complement. The sign bit decides in the
//                 inverted sense whenever a and b differ at the MSB.
//     undefined - unsigned comparison (default).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; a/b latched and scan restarted on accept
//   SCAN  | one operand bit per clock, LSB first; busy=1
//   DONE  | one-cycle done pulse; result registers already hold the answer
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l_out,
  output logic             e_out,
  output logic             g_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    R_EQ = 2'd0,
    R_LT = 2'd1,
    R_GT = 2'd2
  } res_t;

  state_t           state, state_nx;
  res_t             r, r_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IW-1:0]    idx;
  logic             a_bit, b_bit;
  logic             last_bit;

  // The latched operands are shifted right each step, so bit 0 is always the
  // bit under comparison; idx only tracks how far the scan has progressed.
  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign last_bit = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Single shared 1-bit compare stage: a later (higher) bit that differs
  // replaces the running result, equal bits leave it alone.
  always_comb begin
    r_nx = r;
    if (a_bit && !b_bit) begin
      r_nx = R_GT;
    end else if (!a_bit && b_bit) begin
      r_nx = R_LT;
    end
`ifdef SERIAL_CMP_SIGNED_EN
    // A set sign bit means negative, so at the MSB the sense flips.
    if (last_bit && (a_bit != b_bit)) begin
      r_nx = a_bit ? R_LT : R_GT;
    end
`endif
  end

  // Operand capture, scan progress and running result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      idx  <= '0;
      r    <= R_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            idx  <= '0;
            r    <= R_EQ;
          end
        end
        SCAN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r    <= r_nx;
          if (!last_bit) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: loaded with the final decision on the last scan step
  // (including that step's bit) and held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_out <= 1'b0;
      e_out <= 1'b1;
      g_out <= 1'b0;
    end else if ((state == SCAN) && last_bit) begin
      l_out <= (r_nx == R_LT);
      e_out <= (r_nx == R_EQ);
      g_out <= (r_nx == R_GT);
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator (WIDTH=8). Expected results are
// queued when an operation is accepted and popped when the DUT pulses done.
// Honours SERIAL_CMP_SIGNED_EN the same way as the design.
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, l_out, e_out, g_out;

  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  logic [2:0] sb[$];
  logic [2:0] prev_leg = 3'b010;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .l_out (l_out),
    .e_out (e_out),
    .g_out (g_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {lt, eq, gt}
  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef SERIAL_CMP_SIGNED_EN
    if ($signed(x) < $signed(y)) return 3'b100;
    if ($signed(x) > $signed(y)) return 3'b001;
`else
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Monitor: one-hot result, scoreboard pop on done, outputs stable otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_leg = 3'b010;
    end else begin
      checks++;
      if ((32'(l_out) + 32'(e_out) + 32'(g_out)) != 1) begin
        errors++;
        $display("FAIL onehot: l/e/g=%b%b%b, required exactly one high", l_out, e_out, g_out);
      end
      if (done) begin
        done_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=1 with no outstanding operation");
        end else begin
          logic [2:0] exp;
          exp = sb.pop_front();
          if ({l_out, e_out, g_out} !== exp) begin
            errors++;
            $display("FAIL result: l/e/g=%b, required %b", {l_out, e_out, g_out}, exp);
          end
        end
        prev_leg = {l_out, e_out, g_out};
      end else begin
        checks++;
        if ({l_out, e_out, g_out} !== prev_leg) begin
          errors++;
          $display("FAIL stable: l/e/g=%b changed without done, required %b",
                   {l_out, e_out, g_out}, prev_leg);
        end
      end
    end
  end

  // Issue one compare from IDLE and check latency to done.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    int cnt;
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 20 && cnt == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_accept: busy=%b, required 1", busy);
        end
      end
      if (done) cnt = k;
    end
    checks++;
    if (cnt != 9) begin
      errors++;
      $display("FAIL latency: done after %0d cycles (0=timeout), required 9", cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, l_out, e_out, g_out} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_state: busy/done/l/e/g=%b, required 00010",
               {busy, done, l_out, e_out, g_out});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_equal();
    run_op(8'h5A, 8'h5A);
  endtask

  task automatic test_msb();
    run_op(8'h80, 8'h7F);
  endtask

  task automatic test_override();
    run_op(8'h01, 8'h02);
    run_op(8'h02, 8'h01);
    run_op(8'hFF, 8'h00);
    run_op(8'h00, 8'hFF);
  endtask

  task automatic test_ignore_start();
    int got;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    sb.push_back(model(8'h01, 8'h02));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL ignore_done_timeout: done not seen, required 1");
    end
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b, required 0", busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[6];
    logic [7:0] ys[6];
    int d0;
    xs = '{8'h10, 8'h33, 8'h80, 8'h7F, 8'hC4, 8'h00};
    ys = '{8'h20, 8'h33, 8'h01, 8'hFF, 8'hC5, 8'h00};
    d0 = done_seen;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1;
      a     = xs[i];
      b     = ys[i];
      sb.push_back(model(xs[i], ys[i]));
      @(posedge clk);
      repeat (3) @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      repeat (6) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done: op %0d done=%b at accept+9, required 1", i, done);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_seen - d0 != 6) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses, required 6", done_seen - d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid_scan();
    int d0;
    run_op(8'h00, 8'h01);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, l_out, e_out, g_out} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_mid_scan: busy/done/l/e/g=%b, required 00010",
               {busy, done, l_out, e_out, g_out});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    d0 = done_seen;
    repeat (15) @(negedge clk);
    checks++;
    if (done_seen != d0) begin
      errors++;
      $display("FAIL done_after_abort: %0d done pulses, required 0", done_seen - d0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    test_reset();
    test_equal();
    test_msb();
    test_override();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
